// File: rtl/lotr_pkg.sv
// Shared types for the gpc_4t core-to-fabric request port.
// Opcode encoding and the per-thread request bundle.
package lotr_pkg;

  typedef enum logic [1:0] {
    RD     = 2'b00,
    WR     = 2'b01,
    RD_RSP = 2'b10,
    WR_RSP = 2'b11
  } c2f_opcode_t;

  typedef struct packed {
    c2f_opcode_t opcode;
    logic [31:0] address;
    logic [31:0] data;
  } t_c2f_req;

endpackage

// File: rtl/rr_arb4.sv
// Four-way round-robin pick: first request at or after ptr.
// Purely combinational; gnt is one-hot or zero.
module rr_arb4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic [1:0] idx
);

  logic [1:0] cand;
  logic       found;

  // Scan upward from ptr with 2-bit wrap, keep the first hit
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < 4; i++) begin
      cand = ptr + 2'(i);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/gpc_4t_c2f_arb.sv
// Shares the gpc_4t C2F request port among four threads.
// One buffered request per thread, round-robin issue, read-data return.
module gpc_4t_c2f_arb
  import lotr_pkg::*;
#(
  parameter int NUM_THREADS = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                        QClk,
  input  logic                        RstQnnnH,
  input  logic [NUM_THREADS-1:0]      ThrReqValid,
  input  logic [NUM_THREADS-1:0][1:0] ThrReqOpcode,
  input  logic [NUM_THREADS-1:0][31:0] ThrReqAddress,
  input  logic [NUM_THREADS-1:0][31:0] ThrReqData,
  output logic [NUM_THREADS-1:0]      ThrReqReady,
  output logic [NUM_THREADS-1:0]      ThrRspValid,
  output logic [31:0]                 ThrRspData,
  output logic                        C2F_ReqValidQ500H,
  output logic [1:0]                  C2F_ReqOpcodeQ500H,
  output logic [1:0]                  C2F_ReqThreadIDQ500H,
  output logic [31:0]                 C2F_ReqAddressQ500H,
  output logic [31:0]                 C2F_ReqDataQ500H,
  input  logic                        C2F_RspValidQ502H,
  input  logic [1:0]                  C2F_RspOpcodeQ502H,
  input  logic [1:0]                  C2F_RspThreadIDQ502H,
  input  logic [31:0]                 C2F_RspDataQ502H,
  input  logic                        C2F_RspStall,
  output logic                        ErrUnexpRsp,
  output logic [NUM_THREADS-1:0]      ErrTimeout
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYC);

  logic [NUM_THREADS-1:0] pend;
  logic [NUM_THREADS-1:0] outst;
  logic [NUM_THREADS-1:0] acc;
  logic [NUM_THREADS-1:0] arb_req;
  logic [NUM_THREADS-1:0] gnt;
  logic [NUM_THREADS-1:0] rd_rsp;
  logic [NUM_THREADS-1:0] rd_issue;
  logic [1:0]             win;
  logic [1:0]             rr_ptr;
  logic                   issue;
  t_c2f_req               slot [NUM_THREADS];
  logic [CW-1:0]          cnt  [NUM_THREADS];

  assign ThrReqReady = ~pend & ~outst;
  assign acc         = ThrReqValid & ThrReqReady;
  assign arb_req     = C2F_RspStall ? '0 : pend;
  assign issue       = |arb_req;
  assign rd_issue    = (slot[win].opcode == RD) ? gnt : '0;

  rr_arb4 u_arb (
    .req (arb_req),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (win)
  );

  // Decode an incoming read response into a per-thread strobe
  always_comb begin
    rd_rsp = '0;
    if (C2F_RspValidQ502H && C2F_RspOpcodeQ502H == RD_RSP)
      rd_rsp[C2F_RspThreadIDQ502H] = 1'b1;
  end

  // Capture an accepted request into its thread slot
  always_ff @(posedge QClk) begin
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (acc[t]) begin
        slot[t].opcode  <= c2f_opcode_t'(ThrReqOpcode[t]);
        slot[t].address <= ThrReqAddress[t];
        slot[t].data    <= ThrReqData[t];
      end
    end
  end

  // Slot occupancy: pending until issued, reads then wait for data
  always_ff @(posedge QClk) begin
    if (RstQnnnH) begin
      pend  <= '0;
      outst <= '0;
    end else begin
      pend  <= (pend & ~gnt) | acc;
      outst <= (outst & ~rd_rsp) | rd_issue;
    end
  end

  // Registered fabric request; fields hold between issues
  always_ff @(posedge QClk) begin
    if (RstQnnnH) begin
      C2F_ReqValidQ500H    <= 1'b0;
      C2F_ReqOpcodeQ500H   <= '0;
      C2F_ReqThreadIDQ500H <= '0;
      C2F_ReqAddressQ500H  <= '0;
      C2F_ReqDataQ500H     <= '0;
      rr_ptr               <= '0;
    end else begin
      C2F_ReqValidQ500H <= issue;
      if (issue) begin
        C2F_ReqOpcodeQ500H   <= slot[win].opcode;
        C2F_ReqThreadIDQ500H <= win;
        C2F_ReqAddressQ500H  <= slot[win].address;
        C2F_ReqDataQ500H     <= slot[win].data;
        rr_ptr               <= win + 2'd1;
      end
    end
  end

  // Return read data to its owner; flag reads nobody asked for
  always_ff @(posedge QClk) begin
    if (RstQnnnH) begin
      ThrRspValid <= '0;
      ThrRspData  <= '0;
      ErrUnexpRsp <= 1'b0;
    end else begin
      ThrRspValid <= rd_rsp & outst;
      if (|(rd_rsp & outst))
        ThrRspData <= C2F_RspDataQ502H;
      if (|(rd_rsp & ~outst))
        ErrUnexpRsp <= 1'b1;
    end
  end

  // Per-thread saturating wait counters and sticky timeout flags
  always_ff @(posedge QClk) begin
    if (RstQnnnH) begin
      ErrTimeout <= '0;
      for (int t = 0; t < NUM_THREADS; t++)
        cnt[t] <= '0;
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        if (cnt[t] == TO_MAX)
          ErrTimeout[t] <= 1'b1;
        if (rd_issue[t])
          cnt[t] <= '0;
        else if (outst[t] && cnt[t] != TO_MAX)
          cnt[t] <= cnt[t] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gpc_4t_c2f_arb.sv
// Bench for gpc_4t_c2f_arb: directed scenarios plus random traffic.
// A thread-level reference model is compared on every falling edge.
module tb_gpc_4t_c2f_arb;
  import lotr_pkg::*;

  localparam int TO = 1024;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       req_v;
  logic [3:0][1:0]  req_op;
  logic [3:0][31:0] req_a;
  logic [3:0][31:0] req_d;
  logic [3:0]       rdy;
  logic [3:0]       rspv;
  logic [31:0]      rspd;
  logic             cv;
  logic [1:0]       cop;
  logic [1:0]       ctid;
  logic [31:0]      caddr;
  logic [31:0]      cdata;
  logic             fv;
  logic [1:0]       fop;
  logic [1:0]       ftid;
  logic [31:0]      fdata;
  logic             stall;
  logic             eu;
  logic [3:0]       et;

  always #5 clk = ~clk;

  gpc_4t_c2f_arb dut (
    .QClk                 (clk),
    .RstQnnnH             (rst),
    .ThrReqValid          (req_v),
    .ThrReqOpcode         (req_op),
    .ThrReqAddress        (req_a),
    .ThrReqData           (req_d),
    .ThrReqReady          (rdy),
    .ThrRspValid          (rspv),
    .ThrRspData           (rspd),
    .C2F_ReqValidQ500H    (cv),
    .C2F_ReqOpcodeQ500H   (cop),
    .C2F_ReqThreadIDQ500H (ctid),
    .C2F_ReqAddressQ500H  (caddr),
    .C2F_ReqDataQ500H     (cdata),
    .C2F_RspValidQ502H    (fv),
    .C2F_RspOpcodeQ502H   (fop),
    .C2F_RspThreadIDQ502H (ftid),
    .C2F_RspDataQ502H     (fdata),
    .C2F_RspStall         (stall),
    .ErrUnexpRsp          (eu),
    .ErrTimeout           (et)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference model: thread slots, wait ages, fabric register image
  logic [3:0]  m_pend, m_out, m_rv, m_et;
  logic        m_cv, m_eu;
  logic [1:0]  m_cop, m_ctid;
  logic [31:0] m_caddr, m_cdata, m_rd;
  logic [1:0]  s_op [4];
  logic [31:0] s_a  [4];
  logic [31:0] s_d  [4];
  int          age  [4];
  int          m_ptr;
  logic [3:0]  e_rdy;
  bit          mchk = 0;

  assign e_rdy = ~(m_pend | m_out);

  always @(posedge clk) begin : model
    logic [3:0] p0, o0, nv;
    int w;
    bit hit;
    if (rst) begin
      m_pend = '0; m_out = '0; m_rv = '0; m_et = '0;
      m_cv = 0; m_eu = 0; m_cop = '0; m_ctid = '0;
      m_caddr = '0; m_cdata = '0; m_rd = '0; m_ptr = 0;
      for (int t = 0; t < 4; t++) age[t] = 0;
    end else begin
      p0 = m_pend;
      o0 = m_out;
      nv = '0;
      if (fv && fop == 2'b10) begin
        if (o0[ftid]) begin
          nv[ftid] = 1'b1;
          m_rd = fdata;
        end else begin
          m_eu = 1'b1;
        end
      end
      m_rv = nv;
      for (int t = 0; t < 4; t++) begin
        if (age[t] >= TO) m_et[t] = 1'b1;
        if (o0[t] && age[t] < TO) age[t]++;
      end
      m_cv = 0;
      hit = 0;
      w = 0;
      if (!stall)
        for (int k = 0; k < 4; k++)
          if (!hit && p0[(m_ptr + k) % 4]) begin
            hit = 1;
            w = (m_ptr + k) % 4;
          end
      if (hit) begin
        m_cv = 1;
        m_ctid = w[1:0];
        m_cop = s_op[w];
        m_caddr = s_a[w];
        m_cdata = s_d[w];
        m_pend[w] = 1'b0;
        m_ptr = (w + 1) % 4;
        if (s_op[w] == 2'b00) begin
          m_out[w] = 1'b1;
          age[w] = 0;
        end
      end
      m_out = m_out & ~nv;
      for (int t = 0; t < 4; t++)
        if (req_v[t] && !p0[t] && !o0[t]) begin
          s_op[t] = req_op[t];
          s_a[t] = req_a[t];
          s_d[t] = req_d[t];
          m_pend[t] = 1'b1;
        end
    end
  end

  // Compare every visible output against the model
  always @(negedge clk) begin
    if (mchk) begin
      chk("m_ready", rdy, e_rdy);
      chk("m_cvalid", cv, m_cv);
      chk("m_copc", cop, m_cop);
      chk("m_ctid", ctid, m_ctid);
      chk("m_caddr", caddr, m_caddr);
      chk("m_cdata", cdata, m_cdata);
      chk("m_rspv", rspv, m_rv);
      chk("m_rspd", rspd, m_rd);
      chk("m_eunexp", eu, m_eu);
      chk("m_etmo", et, m_et);
    end
  end

  task automatic post(input logic [3:0] m,
                      input logic [1:0] op,
                      input logic [31:0] a);
    for (int t = 0; t < 4; t++) begin
      req_op[t] = op;
      req_a[t] = a;
      req_d[t] = a + 32'(t);
    end
    req_v = m;
    @(negedge clk);
    req_v = '0;
  endtask

  task automatic rsp(input logic [1:0] op,
                     input logic [1:0] tid,
                     input logic [31:0] d);
    fv = 1'b1;
    fop = op;
    ftid = tid;
    fdata = d;
    @(negedge clk);
    fv = 1'b0;
  endtask

  initial begin
    req_v = '0; req_op = '0; req_a = '0; req_d = '0;
    fv = 0; fop = '0; ftid = '0; fdata = '0; stall = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", rdy, 4'b1111);
    chk("rst_cvalid", cv, 0);
    chk("rst_rspv", rspv, 0);
    chk("rst_eunexp", eu, 0);
    chk("rst_etmo", et, 0);
    rst = 0;
    mchk = 1;

    post(4'b0100, RD, 32'h0040_0100);
    chk("rd_lat1", cv, 0);
    @(negedge clk);
    chk("rd_valid", cv, 1);
    chk("rd_tid", ctid, 2);
    chk("rd_op", cop, RD);
    chk("rd_addr", caddr, 32'h0040_0100);
    chk("rd_busy", rdy[2], 0);
    rsp(RD_RSP, 2'd2, 32'hDEAD_BEEF);
    chk("rd_rspv", rspv, 4'b0100);
    chk("rd_rspd", rspd, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("rd_free", rdy, 4'b1111);
    chk("rd_pulse", rspv, 0);

    post(4'b1000, WR, 32'h100);
    @(negedge clk);
    post(4'b1111, WR, 32'h200);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("fair0_v", cv, 1);
      chk("fair0_tid", ctid, i);
      chk("fair0_d", cdata, 32'h200 + i);
    end
    @(negedge clk);
    chk("fair0_end", cv, 0);
    post(4'b0010, WR, 32'h280);
    @(negedge clk);
    post(4'b1111, WR, 32'h300);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("fair2_tid", ctid, (2 + i) % 4);
      chk("fair2_d", cdata, 32'h300 + (2 + i) % 4);
    end

    post(4'b0001, WR, 32'h400);
    @(negedge clk);
    stall = 1;
    post(4'b1010, WR, 32'h500);
    for (int i = 0; i < 5; i++) begin
      chk("stall_quiet", cv, 0);
      @(negedge clk);
    end
    stall = 0;
    @(negedge clk);
    chk("stall_t1", ctid, 1);
    chk("stall_v1", cv, 1);
    chk("stall_a1", caddr, 32'h500);
    chk("stall_d1", cdata, 32'h501);
    @(negedge clk);
    chk("stall_t3", ctid, 3);
    chk("stall_d3", cdata, 32'h503);

    post(4'b0001, RD, 32'h600);
    @(negedge clk);
    req_v = 4'b0001;
    req_op[0] = RD;
    req_a[0] = 32'h700;
    fv = 1; fop = RD_RSP; ftid = 0; fdata = 32'h1234_5678;
    @(negedge clk);
    fv = 0;
    chk("col_rspv", rspv, 4'b0001);
    chk("col_rspd", rspd, 32'h1234_5678);
    chk("col_rdy", rdy[0], 1);
    @(negedge clk);
    req_v = '0;
    chk("col_acc", rdy[0], 0);
    chk("col_nv", cv, 0);
    @(negedge clk);
    chk("col_iss", cv, 1);
    chk("col_tid", ctid, 0);
    chk("col_addr", caddr, 32'h700);
    rsp(RD_RSP, 2'd0, 32'h0BAD_F00D);

    rsp(RD_RSP, 2'd3, 32'h55);
    chk("unexp_err", eu, 1);
    chk("unexp_rspv", rspv, 0);

    post(4'b0010, RD, 32'h800);
    @(negedge clk);
    repeat (1000) @(negedge clk);
    chk("tmo_early", et, 0);
    repeat (40) @(negedge clk);
    chk("tmo_set", et, 4'b0010);

    post(4'b0001, RD, 32'h900);
    @(negedge clk);
    stall = 1;
    post(4'b0100, WR, 32'hA00);
    rst = 1;
    stall = 0;
    @(negedge clk);
    chk("mrst_rdy", rdy, 4'b1111);
    chk("mrst_cv", cv, 0);
    chk("mrst_addr", caddr, 0);
    chk("mrst_rspv", rspv, 0);
    chk("mrst_et", et, 0);
    chk("mrst_eu", eu, 0);
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mrst_noiss", cv, 0);
    end
    rsp(RD_RSP, 2'd0, 32'h77);
    chk("mrst_unexp", eu, 1);
    chk("mrst_rspv0", rspv, 0);

    rst = 1;
    @(negedge clk);
    rst = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int t = 0; t < 4; t++) begin
        req_v[t] = ($urandom_range(0, 2) == 0);
        req_op[t] = 2'($urandom_range(0, 1));
        req_a[t] = $urandom;
        req_d[t] = $urandom;
      end
      stall = ($urandom_range(0, 4) == 0);
      fv = 0;
      if ($urandom_range(0, 1) == 0) begin
        ftid = 2'($urandom_range(0, 3));
        fdata = $urandom;
        fop = ($urandom_range(0, 9) == 0) ? WR_RSP : RD_RSP;
        fv = m_out[ftid] || ($urandom_range(0, 99) == 0);
      end
    end
    req_v = '0;
    fv = 0;
    stall = 0;
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/gpc_4t_c2f_arb.md
Name: gpc_4t_c2f_arb

Overview:
Shares the single core-to-fabric (C2F) request port of gpc_4t among the 4 hardware threads. Each thread posts one remote load/store; the block buffers it, arbitrates round-robin, drives the registered C2F_Req*Q500H outputs and routes C2F_Rsp*Q502H read data back to the owning thread. It sits between the gpc_4t memory-stage remote-access path and the fabric interface.

Parameters:
NUM_THREADS, 4, hardware thread count (fixed; 2-bit thread ID)
TIMEOUT_CYC, 1024, cycles an outstanding read may wait before its timeout error sets

Ports:
QClk  in  1  core clock
RstQnnnH  in  1  synchronous active-high reset
ThrReqValid  in  4  per-thread request valid
ThrReqOpcode  in  4x2  per-thread opcode (RD/WR)
ThrReqAddress  in  4x32  per-thread byte address
ThrReqData  in  4x32  per-thread write data
ThrReqReady  out  4  thread slot may accept a request
ThrRspValid  out  4  per-thread read-data pulse
ThrRspData  out  32  read data for the pulsing thread
C2F_ReqValidQ500H  out  1  fabric request valid
C2F_ReqOpcodeQ500H  out  2  fabric opcode
C2F_ReqThreadIDQ500H  out  2  issuing thread
C2F_ReqAddressQ500H  out  32  address
C2F_ReqDataQ500H  out  32  write data
C2F_RspValidQ502H  in  1  fabric response valid
C2F_RspOpcodeQ502H  in  2  response opcode
C2F_RspThreadIDQ502H  in  2  response thread
C2F_RspDataQ502H  in  32  response data
C2F_RspStall  in  1  fabric back-pressure; blocks issue
ErrUnexpRsp  out  1  sticky: read response to a thread with no outstanding read
ErrTimeout  out  4  sticky per-thread read timeout

Behaviour:
- Reset (synchronous, RstQnnnH=1 at a QClk edge): Pending, Outstanding, all C2F_Req* outputs, ThrRspValid, ThrRspData, ErrUnexpRsp, ErrTimeout, timeout counters cleared to 0; RrPtr=0. Reset mid-transaction drops all buffered and outstanding state; a later response then sets ErrUnexpRsp.
- ThrReqReady[t] = !Pending[t] & !Outstanding[t], driven from flops only.
- Accept: ThrReqValid[t]&ThrReqReady[t] captures opcode/address/data into slot t and sets Pending[t] at the next edge. ThrReqValid with Ready low is ignored; the thread holds its request.
- Arbitration (combinational on Pending): if !C2F_RspStall and any Pending, pick the first set bit at or after RrPtr (wrap 3->0). At the edge: C2F_Req* outputs load the winner, ValidQ500H=1, Pending[win]=0, RrPtr=win+1 mod 4. Otherwise ValidQ500H=0, other outputs hold, RrPtr holds.
- Latency: accept at cycle N -> C2F_ReqValidQ500H high in cycle N+2 minimum. ValidQ500H is a one-cycle pulse per issue. Throughput is 1 issue/cycle.
- RD issue sets Outstanding[win] and clears its timeout counter. WR is posted: the slot frees on issue.
- Response: C2F_RspValidQ502H with opcode RD_RSP and Outstanding[tid]=1 -> at the next edge ThrRspValid[tid]=1 for 1 cycle, ThrRspData=data, Outstanding[tid]=0. RD_RSP with Outstanding[tid]=0 -> ErrUnexpRsp=1 and no ThrRspValid. WR_RSP and other opcodes are ignored.
- Simultaneous response to t and ThrReqValid[t]: Ready is still 0 that cycle; the request is accepted the following cycle.
- C2F_RspStall does not block response routing.
- Timeout: each cycle Outstanding[t]=1, counter t increments, saturating. When it reaches TIMEOUT_CYC, ErrTimeout[t]=1 (sticky). Outstanding stays set.

Decomposition:
- lotr_pkg: c2f_opcode_t enum (RD=2'b00, WR=2'b01, RD_RSP=2'b10, WR_RSP=2'b11); thread request struct t_c2f_req {opcode, address, data}.
- Sub-module rr_arb4: 4-bit request vector plus pointer in; one-hot grant and encoded index out. Purely combinational.

Test Plan:
- Single read: T2 RD addr 0x0040_0100 at cycle 10 -> C2F valid in cycle 12 with TID=2, opcode RD. Response RD_RSP TID=2 data 0xDEADBEEF -> ThrRspValid=4'b0100, data 0xDEADBEEF one cycle later; ThrReqReady[2] returns to 1.
- Fairness: all 4 threads post WR in the same cycle, RrPtr=0 -> issue order TID 0,1,2,3 on consecutive cycles. Repeat with RrPtr=2 -> order 2,3,0,1.
- Stall: C2F_RspStall high for 5 cycles with T1 and T3 pending -> no ValidQ500H during the stall. T1 issues the cycle after stall drops, then T3. Addresses and data are intact.
- Response/request collision: RD_RSP for T0 in the same cycle T0 asserts a new RD -> response delivered; the new request is accepted one cycle later and issued 2 cycles after that.
- Error paths: RD_RSP for T3 with nothing outstanding -> ErrUnexpRsp=1 and ThrRspValid=0. T1 read left unanswered for 1024 cycles -> ErrTimeout=4'b0010.
- Reset mid-flight: assert RstQnnnH with T0 outstanding and T2 pending -> all outputs 0 and ThrReqReady=4'b1111 after the reset edge. No C2F issue occurs for T2.
